// File: rtl/bldc_drive_sequencer.sv
// BLDC drive sequencer: soft-start duty ramp, coast before reversal, timed
// gate-driver reset pulses with bounded retries and a latched error state.
// Ports:
//   sys_clk, reset       clock and synchronous active-high reset
//   enable, direction    drive request and requested rotation (0=none,1=cw,2=ccw)
//   duty_target          requested duty
//   hall_error, fault_n  invalid-hall flag, gate driver fault (active low)
//   clear_fault          pulse that releases the error state
//   duty_out, pwm_enable gated duty and enable for the PWM generator
//   gate_enable          gate driver enable
//   gate_reset_pulse     gate driver reset strobe
//   active_direction     direction currently driven (0 when not driving)
//   retry_count          fault recoveries since the last idle
//   error_cause          bit0 hall error, bit1 retries exhausted (sticky)
//   driver_state         current state encoding
module bldc_drive_sequencer #(
   parameter int unsigned duty_width          = 12,
   parameter int unsigned ramp_step           = 16,
   parameter int unsigned ramp_interval_ticks = 5400,
   parameter int unsigned coast_ticks         = 54000,
   parameter int unsigned reset_pulse_ticks   = 540,
   parameter int unsigned retry_wait_ticks    = 5400,
   parameter int unsigned max_retries         = 3,
   parameter int unsigned retry_width         = $clog2(max_retries + 1) + 1
) (
   input  logic                   sys_clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [1:0]             direction,
   input  logic [duty_width-1:0]  duty_target,
   input  logic                   hall_error,
   input  logic                   fault_n,
   input  logic                   clear_fault,
   output logic [duty_width-1:0]  duty_out,
   output logic                   pwm_enable,
   output logic                   gate_enable,
   output logic                   gate_reset_pulse,
   output logic [1:0]             active_direction,
   output logic [retry_width-1:0] retry_count,
   output logic [1:0]             error_cause,
   output logic [2:0]             driver_state
);

   // Rotation direction encoding
   localparam logic [1:0] DIR_NONE = 2'd0;

   // Timers count down from ticks-1 so a state lasts exactly ticks cycles; 0 acts as 1
   localparam int unsigned RAMP_LOAD  = (ramp_interval_ticks > 0) ? ramp_interval_ticks - 1 : 0;
   localparam int unsigned COAST_LOAD = (coast_ticks > 0) ? coast_ticks - 1 : 0;
   localparam int unsigned PULSE_LOAD = (reset_pulse_ticks > 0) ? reset_pulse_ticks - 1 : 0;
   localparam int unsigned WAIT_LOAD  = (retry_wait_ticks > 0) ? retry_wait_ticks - 1 : 0;
   localparam int unsigned TMAX_A     = (RAMP_LOAD > COAST_LOAD) ? RAMP_LOAD : COAST_LOAD;
   localparam int unsigned TMAX_B     = (PULSE_LOAD > WAIT_LOAD) ? PULSE_LOAD : WAIT_LOAD;
   localparam int unsigned TMAX       = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int unsigned TIMER_W    = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
   localparam int unsigned SUM_W      = duty_width + 1;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RAMP       = 3'd1,
      ST_RUN        = 3'd2,
      ST_COAST      = 3'd3,
      ST_GATE_RESET = 3'd4,
      ST_RETRY_WAIT = 3'd5,
      ST_ERROR      = 3'd6
   } state_t;

   state_t                 state, state_next;
   logic [TIMER_W-1:0]     timer, timer_next;
   logic [duty_width-1:0]  duty_next;
   logic                   pwm_next, gate_next, pulse_next;
   logic [1:0]             dir_next, cause_next;
   logic [retry_width-1:0] retry_next;
   logic [SUM_W-1:0]       duty_sum;
   logic                   timer_zero, retries_left, go_hall, go_fault;

   // State and registered outputs
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         timer            <= '0;
         duty_out         <= '0;
         pwm_enable       <= 1'b0;
         gate_enable      <= 1'b0;
         gate_reset_pulse <= 1'b0;
         active_direction <= DIR_NONE;
         retry_count      <= '0;
         error_cause      <= 2'b00;
      end else begin
         state            <= state_next;
         timer            <= timer_next;
         duty_out         <= duty_next;
         pwm_enable       <= pwm_next;
         gate_enable      <= gate_next;
         gate_reset_pulse <= pulse_next;
         active_direction <= dir_next;
         retry_count      <= retry_next;
         error_cause      <= cause_next;
      end
   end

   assign driver_state = state;

   // Next-state, timer and output computation
   always_comb begin
      state_next   = state;
      timer_next   = (timer != '0) ? timer - TIMER_W'(1) : '0;
      duty_next    = duty_out;
      pwm_next     = 1'b0;
      gate_next    = 1'b0;
      pulse_next   = 1'b0;
      dir_next     = active_direction;
      retry_next   = retry_count;
      cause_next   = error_cause;
      go_hall      = 1'b0;
      go_fault     = 1'b0;
      timer_zero   = (timer == '0);
      retries_left = (retry_count < retry_width'(max_retries));
      // One extra bit so the ramp step can never wrap past full scale
      duty_sum     = {1'b0, duty_out} + SUM_W'(ramp_step);

      case (state)
         ST_IDLE: begin
            if (hall_error) begin
               go_hall = 1'b1;
            end else if (enable && direction != DIR_NONE) begin
               state_next = ST_RAMP;
               dir_next   = direction;
               duty_next  = '0;
               timer_next = TIMER_W'(RAMP_LOAD);
            end
         end

         ST_RAMP, ST_RUN: begin
            if (hall_error) begin
               go_hall = 1'b1;
            end else if (!fault_n) begin
               go_fault = 1'b1;
            end else if (!enable || direction == DIR_NONE) begin
               state_next = ST_IDLE;
            end else if (direction != active_direction) begin
               state_next = ST_COAST;
               timer_next = TIMER_W'(COAST_LOAD);
            end else if (duty_target < duty_out) begin
               // Lower targets are followed at once, no ramp down
               duty_next  = duty_target;
               state_next = ST_RUN;
            end else if (state == ST_RUN) begin
               if (duty_target > duty_out) begin
                  state_next = ST_RAMP;
                  timer_next = TIMER_W'(RAMP_LOAD);
               end
            end else if (duty_target == duty_out) begin
               state_next = ST_RUN;
            end else if (timer_zero) begin
               timer_next = TIMER_W'(RAMP_LOAD);
               if (duty_sum >= {1'b0, duty_target}) begin
                  duty_next  = duty_target;
                  state_next = ST_RUN;
               end else begin
                  duty_next = duty_sum[duty_width-1:0];
               end
            end
         end

         ST_COAST: begin
            // Runs its full length even if the direction reverts meanwhile
            if (hall_error) begin
               go_hall = 1'b1;
            end else if (!fault_n) begin
               go_fault = 1'b1;
            end else if (timer_zero) begin
               if (enable && direction != DIR_NONE) begin
                  state_next = ST_RAMP;
                  dir_next   = direction;
                  duty_next  = '0;
                  timer_next = TIMER_W'(RAMP_LOAD);
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end

         ST_GATE_RESET: begin
            if (timer_zero) begin
               state_next = ST_RETRY_WAIT;
               timer_next = TIMER_W'(WAIT_LOAD);
            end
         end

         ST_RETRY_WAIT: begin
            // fault_n is only judged once the driver has settled
            if (timer_zero) begin
               if (hall_error) begin
                  go_hall = 1'b1;
               end else if (!fault_n) begin
                  go_fault = 1'b1;
               end else if (enable) begin
                  state_next = ST_RAMP;
                  duty_next  = '0;
                  timer_next = TIMER_W'(RAMP_LOAD);
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end

         ST_ERROR: begin
            if (clear_fault && !enable && !hall_error) begin
               state_next = ST_IDLE;
               cause_next = 2'b00;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Shared error / fault-recovery entry
      if (go_hall) begin
         state_next    = ST_ERROR;
         cause_next[0] = 1'b1;
      end else if (go_fault) begin
         if (retries_left) begin
            state_next = ST_GATE_RESET;
            retry_next = retry_count + retry_width'(1);
            timer_next = TIMER_W'(PULSE_LOAD);
         end else begin
            state_next    = ST_ERROR;
            cause_next[1] = 1'b1;
         end
      end

      // Drive outputs follow the state being entered
      pwm_next   = (state_next == ST_RAMP) || (state_next == ST_RUN);
      gate_next  = pwm_next || (state_next == ST_COAST);
      pulse_next = (state_next == ST_GATE_RESET);
      if (!pwm_next) begin
         duty_next = '0;
      end
      if (state_next == ST_IDLE || state_next == ST_ERROR) begin
         dir_next = DIR_NONE;
      end
      if (state_next == ST_IDLE) begin
         retry_next = '0;
      end
   end

endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// Directed bench for bldc_drive_sequencer with small tick parameters.
module tb_bldc_drive_sequencer;

   localparam int unsigned DW = 8;
   localparam int unsigned RW = 3;

   logic          sys_clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [1:0]    direction;
   logic [DW-1:0] duty_target;
   logic          hall_error;
   logic          fault_n;
   logic          clear_fault;
   logic [DW-1:0] duty_out;
   logic          pwm_enable;
   logic          gate_enable;
   logic          gate_reset_pulse;
   logic [1:0]    active_direction;
   logic [RW-1:0] retry_count;
   logic [1:0]    error_cause;
   logic [2:0]    driver_state;

   int checks = 0;
   int errors = 0;

   bldc_drive_sequencer #(
      .duty_width(DW), .ramp_step(4), .ramp_interval_ticks(10), .coast_ticks(20),
      .reset_pulse_ticks(5), .retry_wait_ticks(8), .max_retries(2), .retry_width(RW)
   ) dut (
      .sys_clk(sys_clk), .reset(reset), .enable(enable), .direction(direction),
      .duty_target(duty_target), .hall_error(hall_error), .fault_n(fault_n),
      .clear_fault(clear_fault), .duty_out(duty_out), .pwm_enable(pwm_enable),
      .gate_enable(gate_enable), .gate_reset_pulse(gate_reset_pulse),
      .active_direction(active_direction), .retry_count(retry_count),
      .error_cause(error_cause), .driver_state(driver_state)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle just after the last one
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; direction = 2'd0; duty_target = '0;
      hall_error = 1'b0; fault_n = 1'b1; clear_fault = 1'b0;
      step(2);
      check("rst_state", driver_state, 0);
      check("rst_duty", duty_out, 0);
      check("rst_drive", {pwm_enable, gate_enable, gate_reset_pulse}, 0);
      check("rst_dir_retry_cause", {active_direction, retry_count, error_cause}, 0);
      reset = 1'b0;
      step(1);

      // Soft start CW to 10
      duty_target = 8'd10; direction = 2'd1; enable = 1'b1;
      step(1);
      check("ss_state_e0", driver_state, 1);
      check("ss_duty_e0", duty_out, 0);
      check("ss_pwm_gate_e0", {pwm_enable, gate_enable}, 2'b11);
      check("ss_dir", active_direction, 1);
      step(9);
      check("ss_duty_e9", duty_out, 0);
      step(1);
      check("ss_duty_e10", duty_out, 4);
      step(10);
      check("ss_duty_e20", duty_out, 8);
      check("ss_state_e20", driver_state, 1);
      step(10);
      check("ss_duty_e30", duty_out, 10);
      check("ss_state_e30", driver_state, 2);

      // Reversal CW -> CCW with 20-cycle coast
      direction = 2'd2;
      step(1);
      check("rev_state_r0", driver_state, 3);
      check("rev_drive_r0", {duty_out, pwm_enable, gate_enable}, {8'd0, 1'b0, 1'b1});
      step(19);
      check("rev_state_r19", driver_state, 3);
      check("rev_pwm_r19", pwm_enable, 0);
      step(1);
      check("rev_state_r20", driver_state, 1);
      check("rev_dir_r20", active_direction, 2);
      check("rev_duty_r20", duty_out, 0);
      check("rev_pwm_r20", pwm_enable, 1);
      step(30);
      check("rev_run", {driver_state, duty_out}, {3'd2, 8'd10});

      // Fault recovery: fault_n low for three cycles in RUN
      fault_n = 1'b0;
      step(1);
      check("flt_state_f0", driver_state, 4);
      check("flt_pulse_f0", gate_reset_pulse, 1);
      check("flt_retry_f0", retry_count, 1);
      check("flt_drive_f0", {duty_out, pwm_enable, gate_enable}, 0);
      step(2);
      fault_n = 1'b1;
      step(2);
      check("flt_pulse_f4", gate_reset_pulse, 1);
      step(1);
      check("flt_pulse_f5", gate_reset_pulse, 0);
      check("flt_state_f5", driver_state, 5);
      step(7);
      check("flt_state_f12", driver_state, 5);
      step(1);
      check("flt_state_f13", driver_state, 1);
      check("flt_retry_f13", retry_count, 1);
      check("flt_dir_f13", active_direction, 2);

      // Back to idle clears the retry count
      enable = 1'b0;
      step(1);
      check("idle_state", driver_state, 0);
      check("idle_retry", retry_count, 0);

      // Retry exhaustion with fault_n held low
      enable = 1'b1; direction = 2'd1; duty_target = 8'd0;
      step(2);
      check("exh_run", driver_state, 2);
      fault_n = 1'b0;
      step(1);
      check("exh_g0", {driver_state, retry_count}, {3'd4, 3'd1});
      step(5);
      check("exh_g5", driver_state, 5);
      step(8);
      check("exh_g13", {driver_state, retry_count, gate_reset_pulse}, {3'd4, 3'd2, 1'b1});
      step(5);
      check("exh_g18", driver_state, 5);
      step(8);
      check("exh_err_state", driver_state, 6);
      check("exh_err_cause", error_cause, 2'b10);
      check("exh_err_out", {pulse_snapshot(), active_direction, duty_out}, 0);
      clear_fault = 1'b1;
      step(1);
      clear_fault = 1'b0;
      check("exh_clr_ignored", {driver_state, error_cause}, {3'd6, 2'b10});
      enable = 1'b0; clear_fault = 1'b1; fault_n = 1'b1;
      step(1);
      clear_fault = 1'b0;
      check("exh_clr_state", driver_state, 0);
      check("exh_clr_cause", error_cause, 0);

      // Hall error beats fault in the same cycle
      enable = 1'b1;
      step(2);
      check("pri_run", driver_state, 2);
      hall_error = 1'b1; fault_n = 1'b0;
      step(1);
      check("pri_state", driver_state, 6);
      check("pri_cause", error_cause, 2'b01);
      check("pri_no_pulse", {gate_reset_pulse, retry_count}, 0);
      hall_error = 1'b0; fault_n = 1'b1; enable = 1'b0; clear_fault = 1'b1;
      step(1);
      clear_fault = 1'b0;
      check("pri_clr", {driver_state, error_cause}, 0);

      // Reset in the middle of a gate reset pulse
      enable = 1'b1;
      step(2);
      fault_n = 1'b0;
      step(2);
      check("rstmid_pre", {driver_state, gate_reset_pulse}, {3'd4, 1'b1});
      reset = 1'b1; fault_n = 1'b1; enable = 1'b0;
      step(1);
      check("rstmid_state", driver_state, 0);
      check("rstmid_pulse", gate_reset_pulse, 0);
      check("rstmid_retry", retry_count, 0);
      reset = 1'b0;
      step(1);

      // Saturation near full scale, then an immediate drop
      enable = 1'b1; direction = 2'd1; duty_target = 8'd252;
      step(1);
      step(620);
      check("sat_e620", {driver_state, duty_out}, {3'd1, 8'd248});
      step(10);
      check("sat_e630", {driver_state, duty_out}, {3'd2, 8'd252});
      duty_target = 8'd254;
      step(1);
      check("sat_up_state", {driver_state, duty_out}, {3'd1, 8'd252});
      step(10);
      check("sat_254", {driver_state, duty_out}, {3'd2, 8'd254});
      duty_target = 8'd100;
      step(1);
      check("sat_drop", {driver_state, duty_out}, {3'd2, 8'd100});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   function automatic logic [3:0] pulse_snapshot();
      return {gate_reset_pulse, pwm_enable, gate_enable, 1'b0};
   endfunction

endmodule
